// File: rtl/dm_arbiter.sv
// dm_arbiter: shares a single-port data memory between the CPU MEM stage (port 0)
// and a debug/DMA loader (port 1). Owner-based round-robin with optional locked
// bursts capped at MAX_BURST granted cycles while the other port waits.
module dm_arbiter #(
  parameter int unsigned MAX_BURST = 4,
  parameter int unsigned CNT_W     = 3
) (
  input  logic        CLK,
  input  logic        Reset,
  // port 0: CPU MEM stage
  input  logic        req0,
  input  logic        lock0,
  input  logic        we0,
  input  logic [31:0] addr0,
  input  logic [31:0] wd0,
  input  logic [31:0] pc0,
  // port 1: debug/DMA loader
  input  logic        req1,
  input  logic        lock1,
  input  logic        we1,
  input  logic [31:0] addr1,
  input  logic [31:0] wd1,
  // grants and pipeline stall
  output logic        gnt0,
  output logic        gnt1,
  output logic        stall0,
  output logic [31:0] rdata,
  // data memory side
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wd,
  output logic [31:0] dm_pc,
  input  logic [31:0] dm_rd
);

  typedef enum logic [1:0] {StIdle, StOwn0, StOwn1} state_e;

  localparam logic [CNT_W-1:0] BcntMax = CNT_W'(MAX_BURST - 1);

  state_e           state_q, state_d;
  logic             last_q, last_d;  // 1: port 1 owned last, so port 0 wins a tie
  logic [CNT_W-1:0] bcnt_q, bcnt_d;

  logic own_req, oth_req, own_lock, rel_own;

  // Grants come straight from registered ownership; reset suppresses any access.
  always_comb begin
    gnt0   = (state_q == StOwn0) & req0 & ~Reset;
    gnt1   = (state_q == StOwn1) & req1 & ~Reset;
    stall0 = req0 & ~gnt0;
    dm_we  = (gnt0 & we0) | (gnt1 & we1);
    rdata  = dm_rd;
  end

  // Memory address/data/PC follow the owner; quiet zeros when idle.
  always_comb begin
    dm_addr = 32'h0;
    dm_wd   = 32'h0;
    dm_pc   = 32'h0;
    case (state_q)
      StOwn0: begin
        dm_addr = addr0;
        dm_wd   = wd0;
        dm_pc   = pc0;
      end
      StOwn1: begin
        dm_addr = addr1;
        dm_wd   = wd1;
      end
      default: ;
    endcase
  end

  // Next ownership, last owner and burst count.
  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    bcnt_d   = bcnt_q;
    own_req  = (state_q == StOwn1) ? req1  : req0;
    oth_req  = (state_q == StOwn1) ? req0  : req1;
    own_lock = (state_q == StOwn1) ? lock1 : lock0;
    // Owner gives up the bus when done, when unlocked and contended, or when its
    // locked burst has hit the fairness cap with the other port waiting.
    rel_own  = ~own_req | (oth_req & (~own_lock | (bcnt_q == BcntMax)));

    case (state_q)
      StIdle: begin
        bcnt_d = '0;
        if (req0 & req1) begin
          state_d = last_q ? StOwn0 : StOwn1;
          last_d  = ~last_q;
        end else if (req0) begin
          state_d = StOwn0;
          last_d  = 1'b0;
        end else if (req1) begin
          state_d = StOwn1;
          last_d  = 1'b1;
        end
      end
      StOwn0, StOwn1: begin
        if (rel_own) begin
          bcnt_d = '0;
          if (oth_req) begin
            state_d = (state_q == StOwn0) ? StOwn1 : StOwn0;
            last_d  = (state_q == StOwn0);
          end else if (!own_req) begin
            state_d = StIdle;
          end
        end else if (own_req && (bcnt_q != BcntMax)) begin
          bcnt_d = bcnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with synchronous reset; port 0 wins the first tie.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q <= StIdle;
      last_q  <= 1'b1;
      bcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      bcnt_q  <= bcnt_d;
    end
  end

endmodule
